// File: rtl/sw_target_scheduler.sv
// Binds target sequences to two phase-interleaved Smith-Waterman lanes and returns {id,len,score} in completion order.
// Latency: accepted beat reaches arr_data/arr_enk one cycle later; result appears the cycle after arr_vldk.
// Backpressure: s_ready is registered, set only by lane state and phase; a DONE lane blocks its phase until popped. Optional: SW_SCHED_TIMEOUT_EN.
module sw_target_scheduler #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [1:0]             s_base,
    input  logic [ID_WIDTH-1:0]    s_id,
    input  logic                   s_last,
    output logic [1:0]             arr_data,
    output logic                   arr_en0,
    output logic                   arr_en1,
    output logic                   arr_phase,
    input  logic                   arr_vld0,
    input  logic                   arr_vld1,
    input  logic [SCORE_WIDTH-1:0] arr_res0,
    input  logic [SCORE_WIDTH-1:0] arr_res1,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [ID_WIDTH-1:0]    r_id,
    output logic [LEN_WIDTH-1:0]   r_len,
    output logic [SCORE_WIDTH-1:0] r_score,
    output logic                   r_err
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} lane_st_t;

    lane_st_t               st     [2];
    lane_st_t               st_nxt [2];
    lane_st_t               lane_nxt_ph;
    logic                   ph;
    logic [ID_WIDTH-1:0]    lane_id    [2];
    logic [LEN_WIDTH-1:0]   lane_len   [2];
    logic [SCORE_WIDTH-1:0] lane_score [2];
    logic [SCORE_WIDTH-1:0] res        [2];
    logic [1:0]             vld, tmo, acc_lane, done_evt;
    logic [1:0]             ord, q_ord;     // ord[0] = lane at queue head
    logic [1:0]             cnt, q_cnt;
    logic                   accept, pop, head, s_ready_nxt, feed_any_nxt;

    assign accept    = s_valid & s_ready;
    assign pop       = r_valid & r_ready;
    assign acc_lane  = {accept & ph, accept & ~ph};
    assign vld       = {arr_vld1, arr_vld0};
    assign res[0]    = arr_res0;
    assign res[1]    = arr_res1;
    assign arr_phase = ph;
    assign done_evt[0] = (st[0] == DRAIN) & (vld[0] | tmo[0]);
    assign done_evt[1] = (st[1] == DRAIN) & (vld[1] | tmo[1]);

`ifdef SW_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt     [2];
    logic          lane_err [2];

    assign tmo[0] = (st[0] == DRAIN) && (tcnt[0] == TW'(TIMEOUT - 1));
    assign tmo[1] = (st[1] == DRAIN) && (tcnt[1] == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || st[k] != DRAIN) tcnt[k] <= '0;
            else                       tcnt[k] <= tcnt[k] + TW'(1);
            if (rst)                   lane_err[k] <= 1'b0;
            else if (done_evt[k])      lane_err[k] <= ~vld[k];
        end
    end

    assign r_err = r_valid & lane_err[head];
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo   = 2'b00;
    assign r_err = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            st_nxt[k] = st[k];
            case (st[k])
                IDLE:    if (acc_lane[k]) st_nxt[k] = s_last ? DRAIN : FEED;
                FEED:    if (acc_lane[k] && s_last) st_nxt[k] = DRAIN;
                DRAIN:   if (done_evt[k]) st_nxt[k] = DONE;
                DONE:    if (pop && ord[0] == 1'(k)) st_nxt[k] = IDLE;
                default: st_nxt[k] = IDLE;
            endcase
        end
        // s_ready is registered, so evaluate it for the lane served next cycle
        lane_nxt_ph  = ph ? st_nxt[0] : st_nxt[1];
        feed_any_nxt = (st_nxt[0] == FEED) | (st_nxt[1] == FEED);
        s_ready_nxt  = (lane_nxt_ph == FEED) | ((lane_nxt_ph == IDLE) & ~feed_any_nxt);
    end

    // Completion-order queue of lane indices; lane 0 enqueues first on a tie
    always_comb begin
        q_ord = ord;
        q_cnt = cnt;
        if (pop) begin
            q_ord[0] = ord[1];
            q_cnt    = cnt - 2'd1;
        end
        if (done_evt[0]) begin
            q_ord[q_cnt[0]] = 1'b0;
            q_cnt           = q_cnt + 2'd1;
        end
        if (done_evt[1]) begin
            q_ord[q_cnt[0]] = 1'b1;
            q_cnt           = q_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= 1'b0;
            s_ready  <= 1'b0;
            arr_data <= 2'b00;
            arr_en0  <= 1'b0;
            arr_en1  <= 1'b0;
            ord      <= 2'b00;
            cnt      <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                st[k]         <= IDLE;
                lane_id[k]    <= '0;
                lane_len[k]   <= '0;
                lane_score[k] <= '0;
            end
        end else begin
            ph      <= ~ph;
            s_ready <= s_ready_nxt;
            arr_en0 <= acc_lane[0];
            arr_en1 <= acc_lane[1];
            if (accept) arr_data <= s_base;
            ord     <= q_ord;
            cnt     <= q_cnt;
            for (int k = 0; k < 2; k++) begin
                st[k] <= st_nxt[k];
                if (acc_lane[k]) begin
                    if (st[k] == IDLE) begin
                        lane_id[k]  <= s_id;
                        lane_len[k] <= LEN_WIDTH'(1);
                    end else if (lane_len[k] != '1) begin
                        lane_len[k] <= lane_len[k] + LEN_WIDTH'(1);
                    end
                end
                if (done_evt[k]) lane_score[k] <= vld[k] ? res[k] : '0;
            end
        end
    end

    assign head    = ord[0];
    assign r_valid = (cnt != 2'd0);
    assign r_id    = r_valid ? lane_id[head]    : '0;
    assign r_len   = r_valid ? lane_len[head]   : '0;
    assign r_score = r_valid ? lane_score[head] : '0;

endmodule

// File: tb/tb_sw_target_scheduler.sv
// Directed bench for sw_target_scheduler: lane binding, phase interleave, result ordering, reset and drain behaviour.
module tb_sw_target_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_last;
    logic [1:0]  s_base;
    logic [7:0]  s_id;
    logic [1:0]  arr_data;
    logic        arr_en0, arr_en1, arr_phase;
    logic        arr_vld0, arr_vld1;
    logic [11:0] arr_res0, arr_res1;
    logic        r_valid, r_ready, r_err;
    logic [7:0]  r_id;
    logic [15:0] r_len;
    logic [11:0] r_score;

    int n_assert = 0;
    int n_fail   = 0;

    sw_target_scheduler #(
        .SCORE_WIDTH(12), .ID_WIDTH(8), .LEN_WIDTH(16), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_base(s_base), .s_id(s_id), .s_last(s_last),
        .arr_data(arr_data), .arr_en0(arr_en0), .arr_en1(arr_en1), .arr_phase(arr_phase),
        .arr_vld0(arr_vld0), .arr_vld1(arr_vld1), .arr_res0(arr_res0), .arr_res1(arr_res1),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_len(r_len), .r_score(r_score),
        .r_err(r_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat on the first cycle where s_ready is high in the wanted lane's phase
    task automatic send(input logic [1:0] b, input logic [7:0] id, input logic last, input logic lane);
        int w = 0;
        while (!(s_ready && arr_phase == lane) && w < 12) begin
            step();
            w++;
        end
        chk("send_wait", 32'(w < 12), 32'd1);
        s_valid = 1'b1; s_base = b; s_id = id; s_last = last;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("arr_en0", 32'(arr_en0), 32'(!lane));
        chk("arr_en1", 32'(arr_en1), 32'(lane));
        chk("arr_data", 32'(arr_data), 32'(b));
    endtask

    task automatic chk_res(input string tag, input logic [7:0] id, input logic [15:0] len,
                           input logic [11:0] score);
        chk({tag, "_valid"}, 32'(r_valid), 32'd1);
        chk({tag, "_id"},    32'(r_id),    32'(id));
        chk({tag, "_len"},   32'(r_len),   32'(len));
        chk({tag, "_score"}, 32'(r_score), 32'(score));
        chk({tag, "_err"},   32'(r_err),   32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_en0"},     32'(arr_en0), 32'd0);
        chk({tag, "_en1"},     32'(arr_en1), 32'd0);
        chk({tag, "_data"},    32'(arr_data), 32'd0);
        chk({tag, "_phase"},   32'(arr_phase), 32'd0);
        chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        chk({tag, "_r_id"},    32'(r_id), 32'd0);
        chk({tag, "_r_len"},   32'(r_len), 32'd0);
        chk({tag, "_r_score"}, 32'(r_score), 32'd0);
        chk({tag, "_r_err"},   32'(r_err), 32'd0);
    endtask

    task automatic pulse_vld(input logic v0, input logic [11:0] d0, input logic v1, input logic [11:0] d1);
        arr_vld0 = v0; arr_res0 = d0; arr_vld1 = v1; arr_res1 = d1;
        step();
        arr_vld0 = 1'b0; arr_vld1 = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; s_valid = 1'b0; s_base = 2'b00; s_id = 8'h00; s_last = 1'b0;
        arr_vld0 = 1'b0; arr_vld1 = 1'b0; arr_res0 = '0; arr_res1 = '0; r_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_zero("reset");

        // 1: four beats A,C,G,T all on lane 0
        send(2'b10, 8'h11, 1'b0, 1'b0);
        send(2'b01, 8'h11, 1'b0, 1'b0);
        send(2'b11, 8'h11, 1'b0, 1'b0);
        send(2'b00, 8'h11, 1'b1, 1'b0);
        step();
        chk("t1_drain_no_result", 32'(r_valid), 32'd0);
        pulse_vld(1'b1, 12'h80A, 1'b0, 12'h000);
        chk_res("t1", 8'h11, 16'd4, 12'h80A);
        if (arr_phase != 1'b0) step();
        chk("t1_bp_phase", 32'(arr_phase), 32'd0);
        chk("t1_bp_s_ready", 32'(s_ready), 32'd0);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk("t1_popped", 32'(r_valid), 32'd0);

        // 2: id=1 on lane 0, id=2 on lane 1; lane 1 finishes first
        send(2'b00, 8'h01, 1'b0, 1'b0);
        chk("t2_odd_phase", 32'(arr_phase), 32'd1);
        chk("t2_odd_s_ready", 32'(s_ready), 32'd0);
        send(2'b01, 8'h01, 1'b0, 1'b0);
        send(2'b10, 8'h01, 1'b1, 1'b0);
        send(2'b11, 8'h02, 1'b0, 1'b1);
        send(2'b10, 8'h02, 1'b1, 1'b1);
        pulse_vld(1'b0, 12'h000, 1'b1, 12'h805);
        chk_res("t2_first", 8'h02, 16'd2, 12'h805);
        pulse_vld(1'b1, 12'h807, 1'b0, 12'h000);
        chk("t2_head_kept", 32'(r_id), 32'h02);
        r_ready = 1'b1;
        step();
        chk_res("t2_second", 8'h01, 16'd3, 12'h807);
        step();
        r_ready = 1'b0;
        chk("t2_empty", 32'(r_valid), 32'd0);

        // 3: simultaneous completion with r_ready low
        send(2'b01, 8'h03, 1'b0, 1'b0);
        send(2'b10, 8'h03, 1'b1, 1'b0);
        send(2'b11, 8'h04, 1'b1, 1'b1);
        pulse_vld(1'b1, 12'h111, 1'b1, 12'h222);
        chk_res("t3_head", 8'h03, 16'd2, 12'h111);
        chk("t3_s_ready_a", 32'(s_ready), 32'd0);
        step();
        chk("t3_s_ready_b", 32'(s_ready), 32'd0);
        chk("t3_head_held", 32'(r_id), 32'h03);
        r_ready = 1'b1;
        step();
        chk_res("t3_next", 8'h04, 16'd1, 12'h222);
        step();
        r_ready = 1'b0;
        chk("t3_empty", 32'(r_valid), 32'd0);

        // 4: stray valids while idle, then a single-beat sequence
        pulse_vld(1'b1, 12'h3FF, 1'b1, 12'h3FF);
        chk("t4_stray_a", 32'(r_valid), 32'd0);
        step();
        chk("t4_stray_b", 32'(r_valid), 32'd0);
        send(2'b10, 8'h05, 1'b1, 1'b0);
        step();
        chk("t4_drain", 32'(r_valid), 32'd0);
        pulse_vld(1'b1, 12'h0AB, 1'b0, 12'h000);
        chk_res("t4", 8'h05, 16'd1, 12'h0AB);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;

        // 5: reset with a queued result and lane 1 mid-feed
        send(2'b00, 8'h06, 1'b1, 1'b0);
        pulse_vld(1'b1, 12'h456, 1'b0, 12'h000);
        chk("t5_queued", 32'(r_valid), 32'd1);
        send(2'b11, 8'h07, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        chk_zero("t5_reset");
        rst = 1'b0;
        send(2'b01, 8'h08, 1'b1, 1'b0);
        pulse_vld(1'b1, 12'h123, 1'b0, 12'h000);
        chk_res("t5_after", 8'h08, 16'd1, 12'h123);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;

        // 6: drain with no score returned
        send(2'b10, 8'h09, 1'b1, 1'b0);
`ifdef SW_SCHED_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t6_wait", 32'(r_valid), 32'd0);
        end
        step();
        chk("t6_valid", 32'(r_valid), 32'd1);
        chk("t6_err", 32'(r_err), 32'd1);
        chk("t6_score", 32'(r_score), 32'd0);
        chk("t6_id", 32'(r_id), 32'h09);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (r_valid) seen++;
        end
        chk("t6_no_result", 32'(seen), 32'd0);
        chk("t6_err", 32'(r_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
